// File: rtl/imem_arb.sv
// rtl/imem_arb.sv - single-port instruction memory arbiter between fetch and loader
//
// Purpose:
//   Shares one single-port instruction memory between the fetch stage and a
//   program loader/debug port. The loader normally wins. After BURST_MAX
//   consecutive loader grants while fetch is waiting, fetch gets one grant.
//   With BURST_MAX=0, fetch has strict priority. Read data returns one cycle
//   after a grant. It is routed to whichever requester owned that grant.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   f_req_i, f_addr_i          fetch read request and address
//   f_stall_o                  fetch requested but was not granted this cycle
//   f_rvalid_o, f_rdata_o      fetch read return (cycle after the grant)
//   ld_req_i, ld_we_i          loader request, 1 = write / 0 = read
//   ld_addr_i, ld_wdata_i      loader address and write data
//   ld_gnt_o                   loader access performed this cycle
//   ld_rvalid_o, ld_rdata_o    loader read return (cycle after the grant)
//   mem_en_o, mem_we_o         memory enable / write enable
//   mem_addr_o, mem_wdata_o    memory address / write data (0 when idle)
//   mem_rdata_i                memory read data, one cycle after a read enable
//   stall_cnt_o                saturating count of fetch stall cycles
//
// Configuration:
//   IMEM_ARB_PERF_EN  when defined, stall_cnt_o counts f_stall_o cycles and
//                     saturates at all-ones. Otherwise stall_cnt_o is tied to 0.

module imem_arb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 4,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_stall_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [PERF_W-1:0] stall_cnt_o
);

  // A zero-width counter is illegal, so BURST_MAX=0 keeps a 1-bit counter.
  // That counter is held at 0.
  localparam int CNT_W = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F_RD = 2'd1,
    L_RD = 2'd2
  } rd_state_t;

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             fetch_gnt, ld_gnt;

  // The grant terms include rst. Every output is therefore forced to 0 while
  // reset is asserted, even though the inputs may still be toggling.
  always_comb begin
    fetch_gnt = rst & f_req_i & (~ld_req_i | (burst_q >= CNT_MAX));
    ld_gnt    = rst & ld_req_i & ~fetch_gnt;
  end

  always_comb begin
    state_d     = IDLE;
    burst_d     = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (fetch_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = f_addr_i;
      state_d    = F_RD;
    end else if (ld_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ld_we_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      state_d     = ld_we_i ? IDLE : L_RD;
    end
    // The burst count only grows while fetch is actually waiting.
    // A fetch grant, or fetch going quiet, starts a fresh burst.
    if (ld_gnt && f_req_i) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    f_stall_o   = rst & f_req_i & ~fetch_gnt;
    ld_gnt_o    = ld_gnt;
    f_rvalid_o  = rst & (state_q == F_RD);
    ld_rvalid_o = rst & (state_q == L_RD);
    f_rdata_o   = f_rvalid_o ? mem_rdata_i : '0;
    ld_rdata_o  = ld_rvalid_o ? mem_rdata_i : '0;
  end

`ifdef IMEM_ARB_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (f_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
